pdp8_bin_loader: RTL
====================

Name: pdp8_bin_loader

Overview:
- Hardware loader that parses a PAL binary (BIN-format) byte stream and writes it into PDP-8 memory with no switch-register sequencing.
- Sits upstream of the memory write port. It replaces the manual Deposit/Load_PC switch procedure used to preload programs before the CPU run switch (sw[12]) is raised.
- Verifies the trailing BIN checksum and reports the last origin so the top level can load the PC.

Parameters:
- MEM_WAIT_LIMIT, 255, maximum cycles to wait for mem_finished after a write request before flagging an error.
- CHECK_CHECKSUM, 1, when 0, checksum_ok is forced to 1 at completion.

Ports:
- clk  input  1  system clock; all logic is on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load. Ignored while load_busy=1.
- in_valid  input  1  in_byte holds a frame.
- in_ready  output  1  loader accepts a frame this cycle.
- in_byte  input  8  BIN frame.
- mem_write_enable  output  1  memory write request.
- mem_address  output  12  write address.
- mem_write_data  output  12  write data.
- mem_finished  input  1  memory has completed the write.
- load_busy  output  1  load in progress.
- load_done  output  1  sticky; trailer reached.
- checksum_ok  output  1  valid when load_done=1.
- load_error  output  1  sticky; framing error or memory timeout.
- words_written  output  12  count of data words committed to memory.
- last_origin  output  12  most recent origin committed (start PC).

Behaviour:
- Reset values: all outputs 0. State is IDLE, pending-word slot is empty, checksum accumulator is 0, current address is 0.
- Frame classes:
  - LT (leader/trailer): exactly 8'o200.
  - FIELD: bits[7:6]=2'b11. Accepted and discarded; not added to the checksum.
  - Other bit7=1 values: framing error.
  - ORIG-high: bits[7:6]=2'b01.
  - DATA-high: bits[7:6]=2'b00.
  - Low frame: must have bits[7:6]=2'b00, otherwise framing error.
- A byte is consumed on any cycle with in_valid && in_ready.
- in_ready=1 only in states LEADER, HIGH and LOW.
- States:
  - IDLE: on start, clear load_done, load_error, words_written, the accumulator and the pending slot, then go to LEADER.
  - LEADER: discard LT frames. The first non-LT frame is processed as a high frame and the state goes to LOW.
  - HIGH: an LT frame goes to TRAILER-check. ORIG-high or DATA-high latches the high 6 bits and kind, then goes to LOW.
  - LOW: form word = {high[5:0], low[5:0]}. If the pending slot is full, commit the pending word (see COMMIT). The new word becomes pending. Return to HIGH, or to WRITE if the commit is a data write.
  - WRITE: assert mem_write_enable with mem_address and mem_write_data held stable until mem_finished is sampled high. Then increment the address (12-bit, 7777 wraps to 0000), increment words_written, and go to HIGH. If MEM_WAIT_LIMIT cycles elapse without mem_finished, set load_error and go to ERROR. mem_write_enable is deasserted the cycle after mem_finished.
  - TRAILER-check (one cycle):
    - No pending word, or pending is an origin: set load_error, go to ERROR.
    - Otherwise checksum_ok = (pending data == accumulator[11:0]) or !CHECK_CHECKSUM. Set load_done and go to IDLE. The checksum word is never written to memory.
  - ERROR: load_busy=0. Stay until start or reset.
- COMMIT:
  - Add both 6-bit frames of the pending word to the accumulator, modulo 4096.
  - Origin: address = word, last_origin = word, no memory write.
  - Data: perform the WRITE state.
- load_busy=1 in every state other than IDLE and ERROR.
- Simultaneous start during a busy load is ignored.
- Reset mid-write drops mem_write_enable the next cycle. No partial state survives.
- Memory is never written before its word has been confirmed as not being the checksum (one-word look-behind).

Test Plan:
- Basic load. Bytes 200,200,102,000,012,034,000,050,200 → exactly one write, addr 0200 data 1234. Then load_done=1, checksum_ok=1, words_written=1, last_origin=0200, load_error=0.
- Wrap. Origin 7777, data 0001, 0002, correct checksum → writes 7777←0001 and 0000←0002, words_written=2.
- Bad checksum. Basic load with the final frame changed from 050 to 051 → the single write still occurs; load_done=1, checksum_ok=0. With CHECK_CHECKSUM=0, checksum_ok=1.
- Framing. Low frame 8'o100 → load_error=1, load_busy=0, and no further writes. A FIELD frame 8'o300 mid-stream is ignored and the checksum is still ok.
- Memory timeout and backpressure. Hold mem_finished=0 → load_error after 255 cycles, mem_write_enable=1 throughout. Delay mem_finished by 7 cycles → in_ready stays 0 and address/data stay stable until completion.
- Reset mid-write. Assert reset while mem_write_enable=1 → all outputs 0 on the next cycle. A following start plus the basic stream loads correctly.

Source files
------------

// File: rtl/pdp8_bin_loader.sv
// PDP-8 BIN-format loader: parses a paper-tape byte stream and writes data words
// to memory one word behind the stream, so the trailing checksum is never stored.
module pdp8_bin_loader #(
  parameter int unsigned MEM_WAIT_LIMIT = 255,
  parameter bit          CHECK_CHECKSUM = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  output logic        mem_write_enable,
  output logic [11:0] mem_address,
  output logic [11:0] mem_write_data,
  input  logic        mem_finished,
  output logic        load_busy,
  output logic        load_done,
  output logic        checksum_ok,
  output logic        load_error,
  output logic [11:0] words_written,
  output logic [11:0] last_origin
);

  localparam int unsigned WAIT_W = (MEM_WAIT_LIMIT < 2) ? 1 : $clog2(MEM_WAIT_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEADER,
    S_HIGH,
    S_LOW,
    S_WRITE,
    S_TRAILER,
    S_ERROR
  } state_t;

  state_t            state;
  logic [11:0]       addr;
  logic [11:0]       acc;
  logic [11:0]       pend_word;
  logic              pend_valid;
  logic              pend_orig;
  logic [5:0]        high_bits;
  logic              high_orig;
  logic [WAIT_W-1:0] wait_cnt;

  logic take;
  logic is_lt;
  logic is_field;

  assign in_ready  = state inside {S_LEADER, S_HIGH, S_LOW};
  assign load_busy = !(state inside {S_IDLE, S_ERROR});
  assign take      = in_valid && in_ready;
  assign is_lt     = (in_byte == 8'o200);
  assign is_field  = (in_byte[7:6] == 2'b11);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      load_done        <= 1'b0;
      checksum_ok      <= 1'b0;
      load_error       <= 1'b0;
      words_written    <= '0;
      last_origin      <= '0;
      addr             <= '0;
      acc              <= '0;
      pend_word        <= '0;
      pend_valid       <= 1'b0;
      pend_orig        <= 1'b0;
      high_bits        <= '0;
      high_orig        <= 1'b0;
      wait_cnt         <= '0;
    end else begin
      case (state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            load_done     <= 1'b0;
            load_error    <= 1'b0;
            checksum_ok   <= 1'b0;
            words_written <= '0;
            acc           <= '0;
            pend_valid    <= 1'b0;
            pend_orig     <= 1'b0;
            state         <= S_LEADER;
          end
        end

        // Field-setting frames carry nothing for a single-field loader and are skipped.
        S_LEADER, S_HIGH: begin
          if (take && !is_field) begin
            if (is_lt) begin
              if (state == S_HIGH) state <= S_TRAILER;
            end else if (in_byte[7]) begin
              load_error <= 1'b1;
              state      <= S_ERROR;
            end else begin
              high_bits <= in_byte[5:0];
              high_orig <= in_byte[6];
              state     <= S_LOW;
            end
          end
        end

        // The previous word commits only once a newer word proves it is not the checksum.
        S_LOW: begin
          if (take && !is_field) begin
            if (in_byte[7:6] != 2'b00) begin
              load_error <= 1'b1;
              state      <= S_ERROR;
            end else begin
              pend_word  <= {high_bits, in_byte[5:0]};
              pend_orig  <= high_orig;
              pend_valid <= 1'b1;
              state      <= S_HIGH;
              if (pend_valid) begin
                acc <= acc + 12'(pend_word[11:6]) + 12'(pend_word[5:0]);
                if (pend_orig) begin
                  addr        <= pend_word;
                  last_origin <= pend_word;
                end else begin
                  mem_write_enable <= 1'b1;
                  mem_address      <= addr;
                  mem_write_data   <= pend_word;
                  wait_cnt         <= '0;
                  state            <= S_WRITE;
                end
              end
            end
          end
        end

        S_WRITE: begin
          if (mem_finished) begin
            mem_write_enable <= 1'b0;
            addr             <= addr + 12'd1;
            words_written    <= words_written + 12'd1;
            state            <= S_HIGH;
          end else if (wait_cnt == WAIT_LAST) begin
            mem_write_enable <= 1'b0;
            load_error       <= 1'b1;
            state            <= S_ERROR;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_TRAILER: begin
          if (!pend_valid || pend_orig) begin
            load_error <= 1'b1;
            state      <= S_ERROR;
          end else begin
            checksum_ok <= (pend_word == acc) || !CHECK_CHECKSUM;
            load_done   <= 1'b1;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
